// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scene_pkg
//  Description : Shared scene-loader types: opcodes, vertex/transform words
//                and the instance-descriptor layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package scene_pkg;

  // Command opcodes carried in the first byte of every frame
  localparam logic [7:0] OP_CREATE    = 8'h01;
  localparam logic [7:0] OP_TRANSFORM = 8'h02;
  localparam logic [7:0] OP_COMMIT    = 8'h03;
  localparam logic [7:0] OP_CLEAR     = 8'h04;

  // Default RAM address widths (8192-deep vertex and triangle stores)
  localparam int DEF_VADDR_W = 13;
  localparam int DEF_TADDR_W = 13;

  // Vertex: 14 received bytes with the top nibble dropped
  typedef logic [107:0] vertex_t;

  // Per-instance transform word
  typedef logic [383:0] transform_t;

  // Instance descriptor as written to the instance table
  typedef struct packed {
    logic [DEF_VADDR_W-1:0] vert_base;
    logic [DEF_TADDR_W-1:0] tri_base;
    logic [7:0]             tri_count;
  } inst_desc_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : MSB-first byte-to-word shift assembler. 'word' presents the
//                assembled record including the current input byte, and
//                'done' flags the byte that completes the record.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CNT_W-1:0] cnt;

  assign done = en && (cnt == CNT_W'(NBYTES - 1));

  // Byte position within the current record; wraps after the final byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

  generate
    if (WIDTH > 8) begin : g_shift
      // Only WIDTH-8 bits are kept: leading excess bits fall off the top
      logic [WIDTH-9:0] shreg;

      assign word = {shreg, din};

      // Shift each accepted byte in at the bottom
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shreg <= '0;
        end else if (en) begin
          shreg <= word[WIDTH-9:0];
        end
      end
    end else begin : g_single
      assign word = din[WIDTH-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/scene_loader.sv
`default_nettype none
// ============================================================================
//  Module      : scene_loader
//  Description : Decodes the SPI byte stream into vertex, triangle, instance
//                and transform RAM writes. Tracks allocation pointers and
//                instance ids, and flags protocol errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module scene_loader
  import scene_pkg::*;
#(
  parameter int MAX_VERT = 8192,
  parameter int MAX_TRI  = 8192,
  parameter int VTX_W    = 108,
  parameter int VIDX_W   = 8,
  parameter int TRI_W    = 3 * VIDX_W,
  parameter int XF_W     = 384
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          rx_valid,
  input  logic [7:0]                                    rx_byte,
  input  logic                                          rx_abort,
  output logic                                          vert_we,
  output logic [$clog2(MAX_VERT)-1:0]                   vert_waddr,
  output logic [VTX_W-1:0]                              vert_wdata,
  output logic                                          tri_we,
  output logic [$clog2(MAX_TRI)-1:0]                    tri_waddr,
  output logic [TRI_W-1:0]                              tri_wdata,
  output logic                                          inst_we,
  output logic [7:0]                                    inst_waddr,
  output logic [$clog2(MAX_VERT)+$clog2(MAX_TRI)+8-1:0] inst_wdata,
  output logic                                          xf_we,
  output logic [7:0]                                    xf_waddr,
  output logic [XF_W-1:0]                               xf_wdata,
  output logic [7:0]                                    max_inst,
  output logic                                          create_done,
  output logic                                          err
);

  localparam int VA_W = $clog2(MAX_VERT);
  localparam int TA_W = $clog2(MAX_TRI);
  // Pointers carry one extra bit so a completely full RAM is representable
  localparam int VP_W = VA_W + 1;
  localparam int TP_W = TA_W + 1;
  // Bound-check sums must hold pointer + 255 without wrapping
  localparam int VS_W = (VP_W > 8) ? VP_W + 1 : 9;
  localparam int TS_W = (TP_W > 8) ? TP_W + 1 : 9;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HDR        = 3'd1,
    ST_VERT       = 3'd2,
    ST_TRI        = 3'd3,
    ST_XF_ID      = 3'd4,
    ST_XF_DATA    = 3'd5,
    ST_WRITE_INST = 3'd6
  } state_t;

  state_t state, state_nx;

  logic [7:0]      vcnt, tcnt, vert_k, tri_k, xf_id, next_id;
  logic            hdr_second, discard;
  logic [VP_W-1:0] vert_ptr;
  logic [TP_W-1:0] tri_ptr;

  logic             byte_ok, pk_clr;
  logic             vpk_en, tpk_en, xpk_en;
  logic             vpk_done, tpk_done, xpk_done;
  logic [VTX_W-1:0] vpk_word;
  logic [TRI_W-1:0] tpk_word;
  logic [XF_W-1:0]  xpk_word;
  logic             vert_last, tri_last, hdr_bad;
  logic [VS_W-1:0]  v_end;
  logic [TS_W-1:0]  t_end;

  // An abort in the same cycle as a byte wins and the byte is dropped
  assign byte_ok = rx_valid && !rx_abort;
  assign pk_clr  = rx_abort || (state == ST_IDLE);
  assign vpk_en  = byte_ok && (state == ST_VERT);
  assign tpk_en  = byte_ok && (state == ST_TRI);
  assign xpk_en  = byte_ok && (state == ST_XF_DATA);

  assign vert_last = (vert_k == vcnt - 8'd1);
  assign tri_last  = (tri_k == tcnt - 8'd1);

  // Header checks, evaluated while the tcnt byte is on rx_byte
  assign v_end   = VS_W'(vert_ptr) + VS_W'(vcnt);
  assign t_end   = TS_W'(tri_ptr) + TS_W'(rx_byte);
  assign hdr_bad = (vcnt == 8'd0) || (rx_byte == 8'd0) ||
                   (v_end > VS_W'(MAX_VERT)) || (t_end > TS_W'(MAX_TRI)) ||
                   (next_id == 8'd0);

  byte_packer #(.WIDTH(VTX_W)) u_vert_pk (
    .clk(clk), .rst(rst), .clr(pk_clr), .en(vpk_en), .din(rx_byte),
    .word(vpk_word), .done(vpk_done)
  );

  byte_packer #(.WIDTH(TRI_W)) u_tri_pk (
    .clk(clk), .rst(rst), .clr(pk_clr), .en(tpk_en), .din(rx_byte),
    .word(tpk_word), .done(tpk_done)
  );

  byte_packer #(.WIDTH(XF_W)) u_xf_pk (
    .clk(clk), .rst(rst), .clr(pk_clr), .en(xpk_en), .din(rx_byte),
    .word(xpk_word), .done(xpk_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; abort always returns to IDLE
  always_comb begin
    state_nx = state;
    if (rx_abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_byte == OP_CREATE)         state_nx = ST_HDR;
            else if (rx_byte == OP_TRANSFORM) state_nx = ST_XF_ID;
          end
        end
        ST_HDR: begin
          if (rx_valid && hdr_second) begin
            if (vcnt != 8'd0)         state_nx = ST_VERT;
            else if (rx_byte != 8'd0) state_nx = ST_TRI;
            else                      state_nx = ST_IDLE;
          end
        end
        ST_VERT: begin
          if (vpk_done && vert_last)
            state_nx = (tcnt != 8'd0) ? ST_TRI : ST_IDLE;
        end
        ST_TRI: begin
          if (tpk_done && tri_last)
            state_nx = discard ? ST_IDLE : ST_WRITE_INST;
        end
        ST_XF_ID: begin
          if (rx_valid) state_nx = ST_XF_DATA;
        end
        ST_XF_DATA: begin
          if (xpk_done) state_nx = ST_IDLE;
        end
        ST_WRITE_INST: state_nx = ST_IDLE;
        default:       state_nx = ST_IDLE;
      endcase
    end
  end

  // Record bookkeeping, allocation pointers, status and registered RAM writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vcnt        <= '0;
      tcnt        <= '0;
      vert_k      <= '0;
      tri_k       <= '0;
      xf_id       <= '0;
      hdr_second  <= 1'b0;
      discard     <= 1'b0;
      vert_ptr    <= '0;
      tri_ptr     <= '0;
      next_id     <= 8'd1;
      max_inst    <= '0;
      create_done <= 1'b0;
      err         <= 1'b0;
      vert_we     <= 1'b0;
      vert_waddr  <= '0;
      vert_wdata  <= '0;
      tri_we      <= 1'b0;
      tri_waddr   <= '0;
      tri_wdata   <= '0;
      inst_we     <= 1'b0;
      inst_waddr  <= '0;
      inst_wdata  <= '0;
      xf_we       <= 1'b0;
      xf_waddr    <= '0;
      xf_wdata    <= '0;
    end else begin
      vert_we <= 1'b0;
      tri_we  <= 1'b0;
      inst_we <= 1'b0;
      xf_we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          hdr_second <= 1'b0;
          vert_k     <= '0;
          tri_k      <= '0;
          discard    <= 1'b0;
          if (byte_ok) begin
            case (rx_byte)
              OP_CREATE, OP_TRANSFORM: begin
                // After commit the record is still consumed, just not written
                discard <= create_done;
                if (create_done) err <= 1'b1;
              end
              OP_COMMIT: create_done <= 1'b1;
              OP_CLEAR: begin
                vert_ptr    <= '0;
                tri_ptr     <= '0;
                next_id     <= 8'd1;
                max_inst    <= '0;
                create_done <= 1'b0;
                err         <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_HDR: begin
          if (byte_ok) begin
            if (!hdr_second) begin
              vcnt       <= rx_byte;
              hdr_second <= 1'b1;
            end else begin
              tcnt <= rx_byte;
              if (hdr_bad) begin
                discard <= 1'b1;
                err     <= 1'b1;
              end
            end
          end
        end
        ST_VERT: begin
          if (vpk_done) begin
            vert_k <= vert_k + 8'd1;
            if (!discard) begin
              vert_we    <= 1'b1;
              vert_waddr <= VA_W'(VS_W'(vert_ptr) + VS_W'(vert_k));
              vert_wdata <= vpk_word;
            end
          end
        end
        ST_TRI: begin
          if (tpk_done) begin
            tri_k <= tri_k + 8'd1;
            if (!discard) begin
              tri_we    <= 1'b1;
              tri_waddr <= TA_W'(TS_W'(tri_ptr) + TS_W'(tri_k));
              tri_wdata <= tpk_word;
              // Descriptor goes out alongside the final triangle
              if (tri_last) begin
                inst_we    <= 1'b1;
                inst_waddr <= next_id;
                inst_wdata <= {VA_W'(vert_ptr), TA_W'(tri_ptr), tcnt};
              end
            end
          end
        end
        ST_WRITE_INST: begin
          vert_ptr <= vert_ptr + VP_W'(vcnt);
          tri_ptr  <= tri_ptr + TP_W'(tcnt);
          max_inst <= next_id;
          next_id  <= next_id + 8'd1;
        end
        ST_XF_ID: begin
          if (byte_ok) xf_id <= rx_byte;
        end
        ST_XF_DATA: begin
          if (xpk_done && !discard) begin
            xf_we    <= 1'b1;
            xf_waddr <= xf_id;
            xf_wdata <= xpk_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scene_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scene_loader
//  Description : Scoreboard bench for scene_loader (small RAM depths).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_loader;
  import scene_pkg::*;

  localparam int MV = 16;
  localparam int MT = 16;
  localparam int VA_W = $clog2(MV);
  localparam int TA_W = $clog2(MT);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     rx_valid;
  logic [7:0]               rx_byte;
  logic                     rx_abort;
  logic                     vert_we;
  logic [VA_W-1:0]          vert_waddr;
  logic [107:0]             vert_wdata;
  logic                     tri_we;
  logic [TA_W-1:0]          tri_waddr;
  logic [23:0]              tri_wdata;
  logic                     inst_we;
  logic [7:0]               inst_waddr;
  logic [VA_W+TA_W+8-1:0]   inst_wdata;
  logic                     xf_we;
  logic [7:0]               xf_waddr;
  logic [383:0]             xf_wdata;
  logic [7:0]               max_inst;
  logic                     create_done;
  logic                     err;

  scene_loader #(.MAX_VERT(MV), .MAX_TRI(MT)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_abort(rx_abort),
    .vert_we(vert_we), .vert_waddr(vert_waddr), .vert_wdata(vert_wdata),
    .tri_we(tri_we), .tri_waddr(tri_waddr), .tri_wdata(tri_wdata),
    .inst_we(inst_we), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
    .xf_we(xf_we), .xf_waddr(xf_waddr), .xf_wdata(xf_wdata),
    .max_inst(max_inst), .create_done(create_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    int           addr;
    logic [383:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  // Reference model of the loader's bookkeeping
  int   m_vptr, m_tptr, m_nid, m_max;
  logic m_done, m_err;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic sb_push(input int kind, input int addr, input logic [383:0] data);
    wr_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic we, input int addr, input logic [383:0] data);
    wr_t e;
    if (sb.size() == 0) begin
      check("unexpected_we", we, 1'b0);
    end else begin
      e = sb.pop_front();
      check("we_kind", kind, e.kind);
      check("we_addr", addr, e.addr);
      check("we_data", data, e.data);
    end
  endtask

  // Write monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (vert_we) sb_pop(0, vert_we, int'(vert_waddr), 384'(vert_wdata));
    if (tri_we)  sb_pop(1, tri_we,  int'(tri_waddr),  384'(tri_wdata));
    if (inst_we) sb_pop(2, inst_we, int'(inst_waddr), 384'(inst_wdata));
    if (xf_we)   sb_pop(3, xf_we,   int'(xf_waddr),   xf_wdata);
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_max_inst"}, max_inst, 8'(m_max));
    check({tag, "_err"}, err, m_err);
    check({tag, "_create_done"}, create_done, m_done);
  endtask

  task automatic model_reset();
    m_vptr = 0; m_tptr = 0; m_nid = 1; m_max = 0;
    m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic do_create(input int vc, input int tc);
    logic         bad;
    logic [7:0]   vb [14];
    logic [111:0] full;
    logic [23:0]  tw;
    bad = m_done || vc == 0 || tc == 0 || (m_vptr + vc > MV) || (m_tptr + tc > MT) || m_nid == 0;
    send(OP_CREATE);
    send(8'(vc));
    send(8'(tc));
    for (int k = 0; k < vc; k++) begin
      full = '0;
      for (int b = 0; b < 14; b++) begin
        vb[b] = 8'($urandom);
        full  = {full[103:0], vb[b]};
      end
      if (!bad) sb_push(0, m_vptr + k, 384'(full[107:0]));
      for (int b = 0; b < 14; b++) send(vb[b]);
    end
    for (int k = 0; k < tc; k++) begin
      tw = {8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)};
      if (!bad) begin
        sb_push(1, m_tptr + k, 384'(tw));
        if (k == tc - 1) sb_push(2, m_nid, 384'({4'(m_vptr), 4'(m_tptr), 8'(tc)}));
      end
      send(tw[23:16]);
      send(tw[15:8]);
      send(tw[7:0]);
    end
    if (bad) begin
      m_err = 1'b1;
    end else begin
      m_vptr += vc;
      m_tptr += tc;
      m_max  = m_nid;
      m_nid  = (m_nid + 1) % 256;
    end
    @(posedge clk); #1;
    check_status("create");
  endtask

  task automatic do_xf(input int id);
    logic [7:0]   xb [48];
    logic [383:0] full;
    full = '0;
    for (int b = 0; b < 48; b++) begin
      xb[b] = 8'($urandom);
      full  = {full[375:0], xb[b]};
    end
    if (!m_done) sb_push(3, id, full);
    else         m_err = 1'b1;
    send(OP_TRANSFORM);
    send(8'(id));
    for (int b = 0; b < 48; b++) send(xb[b]);
    check_status("xf");
  endtask

  task automatic do_clear();
    send(OP_CLEAR);
    m_vptr = 0; m_tptr = 0; m_nid = 1; m_max = 0;
    m_done = 1'b0; m_err = 1'b0;
    check_status("clear");
  endtask

  initial begin
    logic [7:0]   vb [14];
    logic [111:0] full;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; rx_abort = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_vert_waddr", vert_waddr, '0);
    check("rst_inst_wdata", inst_wdata, '0);
    check("rst_xf_wdata", xf_wdata, '0);
    check_status("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Two back-to-back creates
    do_create(3, 1);
    do_create(4, 2);

    // Unknown opcode is ignored
    send(8'h55);
    check_status("bad_opcode");

    // Abort together with a valid COMMIT byte drops the byte
    rx_abort = 1'b1; rx_valid = 1'b1; rx_byte = OP_COMMIT;
    @(posedge clk); #1;
    rx_abort = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    @(posedge clk); #1;
    check_status("abort_with_byte");

    // Create aborted after 20 vertex bytes: first vertex is already written
    send(OP_CREATE); send(8'd8); send(8'd1);
    full = '0;
    for (int b = 0; b < 14; b++) begin
      vb[b] = 8'($urandom);
      full  = {full[103:0], vb[b]};
    end
    sb_push(0, m_vptr, 384'(full[107:0]));
    for (int b = 0; b < 14; b++) send(vb[b]);
    for (int b = 0; b < 6; b++) send(8'($urandom));
    rx_abort = 1'b1;
    @(posedge clk); #1;
    rx_abort = 1'b0;
    @(posedge clk); #1;
    check_status("after_abort");
    do_create(2, 1);

    // Zero vertex count is an error, payload still consumed
    do_create(0, 1);
    do_clear();

    // Vertex pointer at MAX_VERT-1, then an overflowing create
    do_create(15, 1);
    do_create(2, 1);
    do_create(1, 1);
    do_clear();

    // Transform to camera, commit, then a locked-out create and transform
    do_xf(0);
    send(OP_COMMIT);
    m_done = 1'b1;
    check_status("commit");
    do_create(1, 1);
    do_xf(3);
    do_clear();

    // Reset in the middle of a transform record
    do_create(1, 1);
    do_xf(5);
    send(OP_TRANSFORM); send(8'd7);
    for (int b = 0; b < 10; b++) send(8'($urandom));
    rst = 1'b1;
    #1;
    check("midrst_xf_waddr", xf_waddr, '0);
    check("midrst_xf_wdata", xf_wdata, '0);
    check("midrst_inst_waddr", inst_waddr, '0);
    check("midrst_tri_wdata", tri_wdata, '0);
    model_reset();
    check_status("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_status("post_rst");

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
